// File: rtl/ifft_8_tx_pkg.sv
// Shared types and constants for the 8-point transmit IFFT.
// Twiddles are W8^k = c - j*s in Q1.14; sample type matches the receive FFT output.
package ifft_8_tx_pkg;

    localparam int N          = 8;
    localparam int CP_LEN_DEF = 2;
    localparam int TW_FRAC    = 14;
    localparam int DATA_W     = 16;
    localparam int TW_W       = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_product_t;

    typedef struct packed {
        logic signed [TW_W-1:0] c;
        logic signed [TW_W-1:0] s;
    } twiddle_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COMPUTE = 2'd1;
    localparam state_t ST_OUTPUT  = 2'd2;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // W8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8)
    function automatic twiddle_t w8(input logic [1:0] k);
        twiddle_t w;
        case (k)
            2'd0:    w = '{c: 16'sd16384,  s: 16'sd0};
            2'd1:    w = '{c: 16'sd11585,  s: 16'sd11585};
            2'd2:    w = '{c: 16'sd0,      s: 16'sd16384};
            default: w = '{c: -16'sd11585, s: 16'sd11585};
        endcase
        return w;
    endfunction

    function automatic complex_product_t conj(input complex_product_t x);
        complex_product_t y;
        y.re = x.re;
        y.im = -x.im;
        return y;
    endfunction

endpackage

// File: rtl/ifft_8_tx_if.sv
// Frame-in / sample-out handshake bundle of the transmit IFFT.
// slave is the IFFT side, master is the producer/consumer side.
interface ifft_8_tx_if;
    import ifft_8_tx_pkg::*;

    complex_product_t [N-1:0] in_frame;
    logic                     in_valid;
    logic                     in_ready;
    complex_product_t         out_sample;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport slave (
        input  in_frame, in_valid, out_ready,
        output in_ready, out_sample, out_valid, out_last
    );

    modport master (
        output in_frame, in_valid, out_ready,
        input  in_ready, out_sample, out_valid, out_last
    );

endinterface

// File: rtl/ifft_8_tx_tw_butterfly.sv
// Radix-2 twiddle butterfly: x = (a + b*W)/2, y = (a - b*W)/2, all truncating.
// Purely combinational; no handshake.
module ifft_8_tx_tw_butterfly
    import ifft_8_tx_pkg::*;
(
    input  complex_product_t i_a,
    input  complex_product_t i_b,
    input  logic [1:0]       i_k,
    output complex_product_t o_x,
    output complex_product_t o_y
);

    localparam int PW = DATA_W + TW_W + 1;

    twiddle_t                 w_w;
    logic signed [PW-1:0]     w_br, w_bi, w_c, w_s;
    logic signed [PW-1:0]     w_pr, w_pi;
    logic signed [DATA_W-1:0] w_tr, w_ti;
    logic signed [DATA_W:0]   w_xr, w_xi, w_yr, w_yi;

    assign w_w  = w8(i_k);
    assign w_br = PW'(i_b.re);
    assign w_bi = PW'(i_b.im);
    assign w_c  = PW'(w_w.c);
    assign w_s  = PW'(w_w.s);

    // (br + j*bi) * (c - j*s), full precision before the Q1.14 rescale
    assign w_pr = w_br * w_c + w_bi * w_s;
    assign w_pi = w_bi * w_c - w_br * w_s;
    assign w_tr = DATA_W'(w_pr >>> TW_FRAC);
    assign w_ti = DATA_W'(w_pi >>> TW_FRAC);

    assign w_xr = (DATA_W+1)'(i_a.re) + (DATA_W+1)'(w_tr);
    assign w_xi = (DATA_W+1)'(i_a.im) + (DATA_W+1)'(w_ti);
    assign w_yr = (DATA_W+1)'(i_a.re) - (DATA_W+1)'(w_tr);
    assign w_yi = (DATA_W+1)'(i_a.im) - (DATA_W+1)'(w_ti);

    assign o_x.re = DATA_W'(w_xr >>> 1);
    assign o_x.im = DATA_W'(w_xi >>> 1);
    assign o_y.re = DATA_W'(w_yr >>> 1);
    assign o_y.im = DATA_W'(w_yi >>> 1);

endmodule

// File: rtl/ifft_8_tx.sv
// 8-point IFFT with cyclic prefix: load 1 cycle, 12 butterfly cycles, then CP_LEN+8 serial samples.
// Frames are only taken while idle; out_ready low freezes the current sample.
module ifft_8_tx
    import ifft_8_tx_pkg::*;
#(
    parameter int CP_LEN = CP_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    ifft_8_tx_if.slave  bus
);

    localparam logic [3:0] LAST_CNT = 4'(CP_LEN + N - 1);

    state_t                   r_state;
    complex_product_t [N-1:0] r_buf;
    logic [1:0]               r_stage;
    logic [1:0]               r_bfly;
    logic [3:0]               r_cnt;

    logic [2:0]               w_a, w_b;
    logic [1:0]               w_k;
    logic [2:0]               w_idx;
    logic                     w_out_vld;
    complex_product_t         w_x, w_y;

    // Pair a = grp*2h + j, b = a + h, k = j*(4>>stage)
    always_comb begin
        w_a = '0;
        w_b = '0;
        w_k = '0;
        case (r_stage)
            2'd0: begin
                w_a = {r_bfly, 1'b0};
                w_b = {r_bfly, 1'b1};
            end
            2'd1: begin
                w_a = {r_bfly[1], 1'b0, r_bfly[0]};
                w_b = {r_bfly[1], 1'b1, r_bfly[0]};
                w_k = {r_bfly[0], 1'b0};
            end
            default: begin
                w_a = {1'b0, r_bfly};
                w_b = {1'b1, r_bfly};
                w_k = r_bfly;
            end
        endcase
    end

    ifft_8_tx_tw_butterfly u_bfly (
        .i_a (r_buf[w_a]),
        .i_b (r_buf[w_b]),
        .i_k (w_k),
        .o_x (w_x),
        .o_y (w_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_buf   <= '0;
            r_stage <= '0;
            r_bfly  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            r_buf[i] <= conj(bus.in_frame[bitrev3(3'(i))]);
                        end
                        r_stage <= '0;
                        r_bfly  <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    r_buf[w_a] <= w_x;
                    r_buf[w_b] <= w_y;
                    r_bfly     <= r_bfly + 2'd1;
                    if (r_bfly == 2'd3) begin
                        if (r_stage == 2'd2) begin
                            r_stage <= '0;
                            r_state <= ST_OUTPUT;
                        end else begin
                            r_stage <= r_stage + 2'd1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (bus.out_ready) begin
                        if (r_cnt == LAST_CNT) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Prefix replays the tail x[N-CP_LEN..N-1] ahead of the body x[0..N-1]
    assign w_idx = (r_cnt < 4'(CP_LEN)) ? 3'(r_cnt + 4'(N - CP_LEN))
                                        : 3'(r_cnt - 4'(CP_LEN));

    assign w_out_vld      = (r_state == ST_OUTPUT);
    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_valid  = w_out_vld;
    assign bus.out_sample = w_out_vld ? conj(r_buf[w_idx]) : '0;
    assign bus.out_last   = w_out_vld && (r_cnt == LAST_CNT);

endmodule

// File: tb/tb_ifft_8_tx.sv
// Directed + random bench for ifft_8_tx against a floating-point IFFT/8 reference.
module tb_ifft_8_tx;
    import ifft_8_tx_pkg::*;

    localparam int CP = 2;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ifft_8_tx_if bus ();

    ifft_8_tx #(.CP_LEN(CP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    complex_product_t [7:0] frame;
    complex_product_t [7:0] frame_b;
    logic signed [15:0]     got_re [16];
    logic signed [15:0]     got_im [16];
    logic                   got_last [16];
    real                    ref_re [8];
    real                    ref_im [8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_close(input string tag, input int idx, input logic signed [15:0] obs, input real exp);
        real d;
        d = real'(obs) - exp;
        checks++;
        assert (d <= 2.0 && d >= -2.0) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0d expected=%f", tag, idx, obs, exp);
        end
    endtask

    // x[n] = (1/8) * sum_k X[k] * exp(+j*2*pi*k*n/8)
    function automatic void model(input complex_product_t [7:0] f);
        for (int n = 0; n < 8; n++) begin
            real sr, si, ang;
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < 8; k++) begin
                ang = 2.0 * PI * real'(k * n) / 8.0;
                sr += real'(f[k].re) * $cos(ang) - real'(f[k].im) * $sin(ang);
                si += real'(f[k].re) * $sin(ang) + real'(f[k].im) * $cos(ang);
            end
            ref_re[n] = sr / 8.0;
            ref_im[n] = si / 8.0;
        end
    endfunction

    task automatic check_frame(input complex_product_t [7:0] f);
        int idx;
        model(f);
        for (int i = 0; i < CP + 8; i++) begin
            idx = (i < CP) ? (8 - CP + i) : (i - CP);
            check_close("sample_re", i, got_re[i], ref_re[idx]);
            check_close("sample_im", i, got_im[i], ref_im[idx]);
            check_eq("out_last", 32'(got_last[i]), 32'(i == CP + 7));
        end
    endtask

    task automatic send_frame(input complex_product_t [7:0] f, input bit keep_valid);
        int b;
        @(negedge clk);
        bus.in_frame = f;
        bus.in_valid = 1'b1;
        b = 0;
        while (!bus.in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        check_eq("accept_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        if (!keep_valid) bus.in_valid = 1'b0;
        check_eq("in_ready_drop", 32'(bus.in_ready), 32'd0);
    endtask

    // Called on the first negedge after accept (cycle 1)
    task automatic check_latency();
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd13);
    endtask

    task automatic receive(input int n, input int stall_after, input bit rnd_ready, input bit tail);
        int cnt, stall, budget;
        bit held_v;
        complex_product_t held;
        cnt = 0;
        stall = 0;
        budget = 0;
        held_v = 1'b0;
        held = '0;
        while (cnt < n && budget < 400) begin
            @(negedge clk);
            budget++;
            if (stall > 0) begin
                bus.out_ready = 1'b0;
                if (!held_v) begin
                    held = bus.out_sample;
                    held_v = 1'b1;
                end else begin
                    check_eq("stall_sample", bus.out_sample, held);
                    check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
                end
                stall--;
            end else begin
                bus.out_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
                if (bus.out_valid && bus.out_ready) begin
                    got_re[cnt]   = bus.out_sample.re;
                    got_im[cnt]   = bus.out_sample.im;
                    got_last[cnt] = bus.out_last;
                    cnt++;
                    if (cnt == stall_after) stall = 5;
                end
            end
        end
        check_eq("sample_count", 32'(cnt), 32'(n));
        if (tail) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);
            check_eq("idle_out_valid", 32'(bus.out_valid), 32'd0);
        end
    endtask

    task automatic rand_frame(output complex_product_t [7:0] f);
        for (int k = 0; k < 8; k++) begin
            f[k].re = 16'(int'($urandom_range(4094)) - 2047);
            f[k].im = 16'(int'($urandom_range(4094)) - 2047);
        end
    endtask

    initial begin
        bus.in_frame  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
        check_eq("rst_out_sample", bus.out_sample, 32'd0);

        // Impulse at DC: every body sample is exactly (100,0)
        frame = '0;
        frame[0].re = 16'sd800;
        send_frame(frame, 1'b0);
        check_latency();
        receive(CP + 8, -1, 1'b0, 1'b1);
        check_frame(frame);
        for (int i = CP; i < CP + 8; i++) begin
            check_eq("imp_re", 32'(got_re[i]), 32'd100);
            check_eq("imp_im", 32'(got_im[i]), 32'd0);
        end

        // Single tone on bin 1 with a 5-cycle stall after four samples
        frame = '0;
        frame[1].re = 16'sd800;
        send_frame(frame, 1'b0);
        check_latency();
        receive(CP + 8, 4, 1'b0, 1'b1);
        check_frame(frame);

        // Second frame held on in_valid while busy is taken only once idle
        rand_frame(frame);
        rand_frame(frame_b);
        send_frame(frame, 1'b1);
        bus.in_frame = frame_b;
        check_latency();
        receive(CP + 8, -1, 1'b0, 1'b1);
        check_frame(frame);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq("busy_accept", 32'(bus.in_ready), 32'd0);
        receive(CP + 8, -1, 1'b0, 1'b1);
        check_frame(frame_b);

        // Reset after three output samples abandons the symbol
        rand_frame(frame);
        send_frame(frame, 1'b0);
        check_latency();
        receive(3, -1, 1'b0, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("mid_rst_sample", bus.out_sample, 32'd0);
        reset = 1'b0;
        rand_frame(frame);
        send_frame(frame, 1'b0);
        check_latency();
        receive(CP + 8, -1, 1'b0, 1'b1);
        check_frame(frame);

        // Random frames with random downstream readiness
        for (int r = 0; r < 6; r++) begin
            rand_frame(frame);
            send_frame(frame, 1'b0);
            receive(CP + 8, -1, 1'b1, 1'b1);
            check_frame(frame);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifft_8_tx.md
Name: ifft_8_tx

Overview:
- 8-point inverse FFT for the OFDM transmit path: the transmit-side counterpart of the receive-side 8-point FFT.
- Accepts one parallel frequency-domain frame (8 subcarriers, same array format the FFT emits) through a valid/ready handshake.
- Computes the IFFT in place with one time-multiplexed twiddle butterfly, then streams time-domain samples serially with a cyclic prefix prepended.
- Sits between the subcarrier mapper and the DAC/channel model.

Parameters:
- N, 8, transform size; only 8 supported.
- CP_LEN, 2, cyclic-prefix length in samples; legal range 0..N-1.
- TW_FRAC, 14, fractional bits of the signed twiddle constants.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_frame  in  complex_product_t[N-1:0]  subcarrier symbols X[0..7]
- in_valid  in  1  in_frame valid
- in_ready  out  1  block idle and able to accept a frame
- out_sample  out  complex_product_t  time-domain sample
- out_valid  out  1  out_sample valid
- out_ready  in  1  downstream accepts out_sample
- out_last  out  1  marks the final sample (x[7]) of the symbol

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_sample=0, buffer cleared.
- Method: x = conj(FFT(conj(X)))/8, using radix-2 DIT with twiddles W8^k = exp(-j2πk/8).
- IDLE:
  - in_ready=1.
  - Frame is accepted when in_valid && in_ready.
  - On accept, buf[i] <= conj(in_frame[bitrev3(i)]), then go to COMPUTE.
  - in_ready drops the cycle after accept.
- COMPUTE:
  - 3 stages × 4 butterflies, one butterfly per cycle: 12 cycles.
  - Counters: stage (0..2) and bfly (0..3).
  - Stage s has span h = 1<<s.
  - Pair indices are a = grp*2h + j and b = a + h, with twiddle index k = j*(4>>s).
  - Butterfly: t = buf[b]*W^k, computed as full product, arithmetic shift right by TW_FRAC (truncate).
  - Results: buf[a] <= (buf[a]+t)>>>1 and buf[b] <= (buf[a]-t)>>>1.
  - The per-stage halving gives the total 1/8 scale and prevents overflow; sums are formed one bit wider before the shift.
  - After stage 2, bfly 3, go to OUTPUT.
- OUTPUT:
  - Emits CP_LEN+8 samples.
  - Read index sequence: 8-CP_LEN .. 7, then 0 .. 7.
  - out_sample = conj(buf[idx]).
  - Index advances only on out_valid && out_ready.
  - When out_ready=0, out_sample and out_valid are held stable.
  - out_last=1 only with idx 7 of the main body, not with CP samples.
  - After the last handshake, go to IDLE with in_ready=1 the next cycle.
- Latency: accept at cycle 0, first out_valid at cycle 13 (1 load + 12 compute).
- Frames offered while busy are ignored: in_valid while in_ready=0 has no effect.
- CP_LEN=0: output is the 8 body samples only.
- Reset mid-operation, in any state: returns to reset values next cycle; any partial output is abandoned.

Decomposition:
- Shared package:
  - bitrev3 function
  - W8 twiddle constant table (cos/sin of k=0..3, Q1.TW_FRAC; 0.7071 → 11585)
  - state enum (IDLE, COMPUTE, OUTPUT)
  - existing complex_product_t
- Sub-module tw_butterfly: combinational complex multiply-by-twiddle plus add/sub with >>>1. Reusable by a future multi-point IFFT.

Test Plan:
- Impulse X[0]=(800,0), others 0 → all 8 body samples (100,0); with CP_LEN=2, 10 samples total, out_last on the 10th.
- X[1]=(800,0) → x[n]=100·exp(+j2πn/8): (100,0),(70,70),(0,100),(-70,70),(-100,0),(-70,-70),(0,-100),(70,-70) within ±2 LSB; CP samples equal x[6],x[7].
- Backpressure: hold out_ready=0 for 5 cycles mid-stream → out_sample/out_valid frozen; no sample lost or duplicated.
- Busy rejection: in_valid held high with a second frame during COMPUTE → ignored; second frame accepted only in the cycle in_ready returns to 1, with a correct result.
- Reset asserted during OUTPUT after 3 samples → next cycle out_valid=0, in_ready=1; a fresh frame then produces the correct full output.
- Random frames (±2047) vs. golden model (float IFFT/8) → error ≤2 LSB, no overflow.
